dfi_phy_init_resp: RTL and testbench

//   PHY-side responder for the DFI initialization interface: the far end of the

---
 rtl/dfi_phy_init_resp.sv | 151 +++++++++++++++
 tb/tb_dfi_phy_init_resp.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfi_phy_init_resp.sv
// PHY-side responder for the DFI initialization handshake.
// Watches the controller's reset/CKE/init_start requests and checks the
// DRAM reset and CKE timing. It drives the DRAM RESET#/CKE pins and reports
// init_complete once a fixed calibration interval has elapsed.
// Every output is registered and changes one cycle after the input is sampled.
module dfi_phy_init_resp #(
  parameter int CNT_W           = 20,
  parameter int T_RESET_MIN_CYC = 80000,
  parameter int T_CKE_CYC       = 200000,
  parameter int T_CAL_CYC       = 512
) (
  input  logic       core_clk,
  input  logic       core_arstn,
  input  logic       dfi_reset_n,
  input  logic       dfi_cke,
  input  logic       dfi_init_start,
  output logic       dfi_init_complete,
  output logic       ddr_reset_n,
  output logic       ddr_cke,
  output logic       init_error,
  output logic [2:0] init_state
);

  typedef enum logic [2:0] {
    PWR_UP   = 3'd0,
    RST_HOLD = 3'd1,
    CKE_WAIT = 3'd2,
    STABLE   = 3'd3,
    CAL      = 3'd4,
    READY    = 3'd5,
    ERR      = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_MIN = CNT_W'(T_RESET_MIN_CYC);
  localparam logic [CNT_W-1:0] CKE_MIN = CNT_W'(T_CKE_CYC);
  localparam logic [CNT_W-1:0] CAL_LEN = CNT_W'(T_CAL_CYC);

  // Timing parameters must fit the counter, otherwise the thresholds would truncate.
  if (CNT_W < 2 || CNT_W > 62) begin : g_bad_cnt_w
    $error("dfi_phy_init_resp: CNT_W out of range");
  end
  if (T_RESET_MIN_CYC < 0 || longint'(T_RESET_MIN_CYC) > longint'(CNT_MAX)) begin : g_bad_t_rst
    $error("dfi_phy_init_resp: T_RESET_MIN_CYC does not fit in CNT_W bits");
  end
  if (T_CKE_CYC < 0 || longint'(T_CKE_CYC) > longint'(CNT_MAX)) begin : g_bad_t_cke
    $error("dfi_phy_init_resp: T_CKE_CYC does not fit in CNT_W bits");
  end
  if (T_CAL_CYC < 0 || longint'(T_CAL_CYC) > longint'(CNT_MAX)) begin : g_bad_t_cal
    $error("dfi_phy_init_resp: T_CAL_CYC does not fit in CNT_W bits");
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             complete_q;
  logic             rstn_q;
  logic             cke_q;
  logic             err_q;

  // Saturating increment: a very long reset hold must never wrap back below the minimum.
  always_comb begin
    cnt_inc_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  end

  // Init FSM. A controller reset request overrides every other condition.
  // The outputs are set on the transition edge, so they always match the new state.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      state_q    <= PWR_UP;
      cnt_q      <= '0;
      complete_q <= 1'b0;
      rstn_q     <= 1'b0;
      cke_q      <= 1'b0;
      err_q      <= 1'b0;
    end else if (!dfi_reset_n) begin
      state_q    <= RST_HOLD;
      cnt_q      <= (state_q == RST_HOLD) ? cnt_inc_d : CNT_ONE;
      complete_q <= 1'b0;
      rstn_q     <= 1'b0;
      cke_q      <= 1'b0;
    end else begin
      case (state_q)
        PWR_UP: begin
          // Stay here until the controller first asserts reset.
        end
        RST_HOLD: begin
          if (cnt_q >= RST_MIN) begin
            state_q <= CKE_WAIT;
            cnt_q   <= CNT_ONE;
            rstn_q  <= 1'b1;
          end else begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end
        end
        CKE_WAIT: begin
          // Once the wait has elapsed, a CKE request is legal in the very same cycle.
          if (cnt_q >= CKE_MIN) begin
            state_q <= STABLE;
          end else if (dfi_cke) begin
            state_q <= ERR;
            err_q   <= 1'b1;
            rstn_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        STABLE: begin
          cke_q <= dfi_cke;
          if (dfi_init_start) begin
            state_q <= CAL;
            cnt_q   <= CNT_ONE;
          end
        end
        CAL: begin
          cke_q <= dfi_cke;
          if (!dfi_init_start) begin
            state_q <= STABLE;
          end else if (cnt_q >= CAL_LEN) begin
            state_q    <= READY;
            complete_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        READY: begin
          cke_q <= dfi_cke;
        end
        ERR: begin
          // Only a new controller reset request leaves this state.
        end
        default: begin
          state_q    <= ERR;
          err_q      <= 1'b1;
          complete_q <= 1'b0;
          rstn_q     <= 1'b0;
          cke_q      <= 1'b0;
        end
      endcase
    end
  end

  assign dfi_init_complete = complete_q;
  assign ddr_reset_n       = rstn_q;
  assign ddr_cke           = cke_q;
  assign init_error        = err_q;
  assign init_state        = state_q;

endmodule

// File: tb/tb_dfi_phy_init_resp.sv
// Scoreboard bench for dfi_phy_init_resp with short timing parameters.
// The driver applies one input vector per cycle on the falling edge and pushes
// the response the reference model predicts. The monitor pops that response
// after the next rising edge and compares it with the DUT outputs.
module tb_dfi_phy_init_resp;

  localparam int CNT_W = 20;
  localparam int T_RST = 10;
  localparam int T_CKE = 20;
  localparam int T_CAL = 8;

  // Phase numbering of the reported debug state.
  localparam int S_PWR_UP   = 0;
  localparam int S_RST_HOLD = 1;
  localparam int S_CKE_WAIT = 2;
  localparam int S_STABLE   = 3;
  localparam int S_CAL      = 4;
  localparam int S_READY    = 5;
  localparam int S_ERR      = 6;

  logic       core_clk = 1'b0;
  logic       core_arstn = 1'b1;
  logic       dfi_reset_n = 1'b1;
  logic       dfi_cke = 1'b0;
  logic       dfi_init_start = 1'b0;
  logic       dfi_init_complete;
  logic       ddr_reset_n;
  logic       ddr_cke;
  logic       init_error;
  logic [2:0] init_state;

  always #5 core_clk = ~core_clk;

  dfi_phy_init_resp #(
    .CNT_W          (CNT_W),
    .T_RESET_MIN_CYC(T_RST),
    .T_CKE_CYC      (T_CKE),
    .T_CAL_CYC      (T_CAL)
  ) dut (
    .core_clk         (core_clk),
    .core_arstn       (core_arstn),
    .dfi_reset_n      (dfi_reset_n),
    .dfi_cke          (dfi_cke),
    .dfi_init_start   (dfi_init_start),
    .dfi_init_complete(dfi_init_complete),
    .ddr_reset_n      (ddr_reset_n),
    .ddr_cke          (ddr_cke),
    .init_error       (init_error),
    .init_state       (init_state)
  );

  typedef struct packed {
    logic       comp;
    logic       rstn;
    logic       cke;
    logic       err;
    logic [2:0] st;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    failures = 0;
  string scen = "init";

  // Reference model: current phase, cycles counted in that phase, sticky error.
  int m_st  = S_PWR_UP;
  int m_cnt = 0;
  bit m_err = 1'b0;
  bit m_cke = 1'b0;

  function automatic exp_t model_out();
    exp_t e;
    e.comp = (m_st == S_READY);
    e.rstn = (m_st == S_CKE_WAIT || m_st == S_STABLE || m_st == S_CAL || m_st == S_READY);
    e.cke  = m_cke;
    e.err  = m_err;
    e.st   = 3'(m_st);
    return e;
  endfunction

  task automatic model_reset();
    m_st  = S_PWR_UP;
    m_cnt = 0;
    m_err = 1'b0;
    m_cke = 1'b0;
  endtask

  // Advance the model by one sampled cycle with controller inputs r/c/s.
  task automatic model_step(bit r, bit c, bit s);
    int prev;
    bit oper;
    prev = m_st;
    oper = (prev == S_STABLE || prev == S_CAL || prev == S_READY);
    if (!r) begin
      m_cnt = (prev == S_RST_HOLD) ? m_cnt + 1 : 1;
      m_st  = S_RST_HOLD;
    end else begin
      case (prev)
        S_RST_HOLD: begin
          if (m_cnt >= T_RST) begin m_st = S_CKE_WAIT; m_cnt = 1; end
          else m_st = S_ERR;
        end
        S_CKE_WAIT: begin
          if (m_cnt >= T_CKE) m_st = S_STABLE;
          else if (c) m_st = S_ERR;
          else m_cnt = m_cnt + 1;
        end
        S_STABLE: if (s) begin m_st = S_CAL; m_cnt = 1; end
        S_CAL: begin
          if (!s) m_st = S_STABLE;
          else if (m_cnt >= T_CAL) m_st = S_READY;
          else m_cnt = m_cnt + 1;
        end
        default: ;
      endcase
    end
    // CKE pin tracks the request only while the DRAM was already operational.
    m_cke = r && oper && c;
    if (m_st == S_ERR) m_err = 1'b1;
  endtask

  task automatic check(string tag, exp_t e);
    exp_t a;
    a = {dfi_init_complete, ddr_reset_n, ddr_cke, init_error, init_state};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t: got comp=%0b rstn=%0b cke=%0b err=%0b st=%0d, expected comp=%0b rstn=%0b cke=%0b err=%0b st=%0d",
               tag, $time, a.comp, a.rstn, a.cke, a.err, a.st, e.comp, e.rstn, e.cke, e.err, e.st);
    end else begin
      $display("ok   %s t=%0t comp=%0b rstn=%0b cke=%0b err=%0b st=%0d",
               tag, $time, a.comp, a.rstn, a.cke, a.err, a.st);
    end
  endtask

  // One cycle of stimulus: a=core_arstn, r/c/s = dfi_reset_n/dfi_cke/dfi_init_start.
  task automatic step(bit a, bit r, bit c, bit s);
    bit was_up;
    @(negedge core_clk);
    was_up         = core_arstn;
    core_arstn     = a;
    dfi_reset_n    = r;
    dfi_cke        = c;
    dfi_init_start = s;
    if (!a) model_reset();
    else model_step(r, c, s);
    if (!a && was_up) begin
      #1;
      check({scen, "_async"}, model_out());
    end
    exp_q.push_back(model_out());
    tag_q.push_back(scen);
  endtask

  task automatic hold(bit r, bit c, bit s, int n);
    repeat (n) step(1'b1, r, c, s);
  endtask

  // Reset pulse of len cycles, CKE raised after cke_dly cycles, then a complete calibration.
  task automatic full_init(int len, int cke_dly);
    hold(1'b0, 1'b0, 1'b0, len);
    hold(1'b1, 1'b0, 1'b0, cke_dly);
    hold(1'b1, 1'b1, 1'b0, 3);
    hold(1'b1, 1'b1, 1'b1, T_CAL + 3);
  endtask

  // Monitor: pops one predicted response per rising edge while any are pending.
  initial begin
    forever begin
      @(posedge core_clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, e);
      end
    end
  end

  initial begin
    #1 core_arstn = 1'b0;
    #1;
    model_reset();
    check("reset_state", model_out());
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    scen = "nominal";
    hold(1'b1, 1'b0, 1'b0, 3);
    full_init(12, 25);
    hold(1'b1, 1'b1, 1'b0, 3);

    scen = "short_reset";
    hold(1'b0, 1'b0, 1'b0, 5);
    hold(1'b1, 1'b0, 1'b0, 4);
    scen = "after_err";
    full_init(12, 22);

    scen = "early_cke";
    hold(1'b0, 1'b0, 1'b0, 12);
    hold(1'b1, 1'b0, 1'b0, 9);
    hold(1'b1, 1'b1, 1'b0, 4);

    scen = "cal_abort";
    hold(1'b0, 1'b0, 1'b0, 12);
    hold(1'b1, 1'b0, 1'b0, 21);
    hold(1'b1, 1'b1, 1'b0, 2);
    hold(1'b1, 1'b1, 1'b1, 4);
    hold(1'b1, 1'b1, 1'b0, 2);
    hold(1'b1, 1'b1, 1'b1, T_CAL + 2);

    scen = "rereset_ready";
    hold(1'b0, 1'b1, 1'b1, 2);
    hold(1'b1, 1'b0, 1'b0, 2);

    scen = "async_mid_cal";
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 1'b0, 1'b0, 1);
    hold(1'b0, 1'b0, 1'b0, 11);
    hold(1'b1, 1'b0, 1'b0, 20);
    hold(1'b1, 1'b1, 1'b1, 5);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    hold(1'b1, 1'b1, 1'b1, 2);

    scen = "rand_seq";
    for (int i = 0; i < 8; i++) begin
      int len;
      int dly;
      int st_len;
      len    = $urandom_range(3, 14);
      dly    = $urandom_range(12, 26);
      st_len = $urandom_range(2, 12);
      hold(1'b0, 1'b0, 1'b0, len);
      hold(1'b1, 1'b0, 1'b0, dly);
      hold(1'b1, 1'b1, 1'b0, $urandom_range(0, 3));
      hold(1'b1, 1'b1, 1'b1, st_len);
      hold(1'b1, ($urandom_range(0, 1) == 1), 1'b0, $urandom_range(1, 3));
      hold(1'b1, 1'b1, 1'b1, $urandom_range(5, 11));
    end

    scen = "rand_bits";
    for (int i = 0; i < 150; i++) begin
      step(1'b1, ($urandom_range(0, 15) != 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) != 0));
    end

    // Let the monitor drain the remaining predictions, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge core_clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d predictions still pending, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
